ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the basic processor.
- Fetches 9-bit instruction words, decodes the 4-bit opcode map, and sequences the ALU, register-file and data-memory strobes.
- Updates the PC, including branch and jump targets.
- Sits between the instruction ROM and the datapath. It is the consumer of the opcode encoding that the assembler produces.

---
 rtl/ctrl_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute sequencer for the basic processor.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module ctrl_fsm #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int MEM_TO  = 15
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               alu_flag_z,
  input  logic               alu_flag_n,
  output logic [3:0]         alu_op,
  output logic [4:0]         operand,
  output logic               reg_we,
  output logic               mem_re,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic               done,
  output logic               err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        cycle_cnt,
  output logic [15:0]        instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0, OP_SUB = 4'h1, OP_BEQ    = 4'h2, OP_SL  = 4'h3,
    OP_SR     = 4'h4, OP_LW  = 4'h5, OP_SW     = 4'h6, OP_INVERT = 4'h7,
    OP_MOV    = 4'h8, OP_ASSIGN = 4'h9, OP_BGE = 4'hA, OP_BNE = 4'hB,
    OP_JMP    = 4'hC
  } opcode_t;

  localparam int WAIT_W = $clog2(MEM_TO + 1);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               reg_we_q, reg_we_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [3:0]         op;
  logic [3:0]         dec_op;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_rel;
  logic               br_taken;

  assign op     = ir_q[INSTR_W-1 -: 4];
  assign dec_op = instr_in[INSTR_W-1 -: 4];
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};

  function automatic logic writes_reg(input logic [3:0] o);
    case (o)
      OP_ADD, OP_SUB, OP_SL, OP_SR, OP_INVERT, OP_MOV, OP_ASSIGN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (op)
      OP_BEQ:  br_taken = alu_flag_z;
      OP_BNE:  br_taken = !alu_flag_z;
      OP_BGE:  br_taken = !alu_flag_n;
      OP_JMP:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Strobes are computed for the state being entered so they come straight off flops.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    wait_d   = wait_q;
    reg_we_d = 1'b0;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instr_in;
        if (instr_in == '1) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (dec_op >= 4'hD) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d  = S_EXEC;
          reg_we_d = writes_reg(dec_op);
        end
      end
      S_EXEC: begin
        case (op)
          OP_LW: begin
            state_d  = S_MEM;
            wait_d   = '0;
            mem_re_d = 1'b1;
          end
          OP_SW: begin
            state_d  = S_MEM;
            wait_d   = '0;
            mem_we_d = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BGE, OP_JMP: begin
            pc_d    = br_taken ? pc_rel : pc_inc;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op == OP_LW) begin
            state_d  = S_WB;
            reg_we_d = 1'b1;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_W'(MEM_TO - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d   = wait_q + WAIT_W'(1);
          mem_re_d = (op == OP_LW);
          mem_we_d = (op == OP_SW);
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end else begin
          done_d = 1'b1;
        end
      end
      S_ERR:   err_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      wait_q   <= '0;
      reg_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wait_q   <= wait_d;
      reg_we_q <= reg_we_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign instr_addr = pc_q;
  assign alu_op     = op;
  assign operand    = ir_q[4:0];
  assign reg_we     = reg_we_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic        accept, busy, retire;

  always_comb begin
    accept      = start && (state_q == S_IDLE || state_q == S_HALT);
    busy        = !(state_q inside {S_IDLE, S_HALT, S_ERR});
    retire      = (state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB});
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (accept) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      if (busy && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 16'd1;
      if (retire && instr_cnt_q != '1) instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: per-cycle expected outputs are queued when a
// program is launched and compared on each falling edge.
module tb_ctrl_fsm;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int MEM_TO  = 15;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_BEQ = 4'h2, OP_SL = 4'h3;
  localparam logic [3:0] OP_SR = 4'h4, OP_LW = 4'h5, OP_SW = 4'h6, OP_INV = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8, OP_ASG = 4'h9, OP_BGE = 4'hA, OP_BNE = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [8:0] W_HALT = 9'h1FF;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               start;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_in;
  logic               alu_flag_z, alu_flag_n;
  logic [3:0]         alu_op;
  logic [4:0]         operand;
  logic               reg_we, mem_re, mem_we, mem_ack, done, err;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0]        cycle_cnt, instr_cnt;
`endif

  always #5 Clk = ~Clk;

  ctrl_fsm #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_TO(MEM_TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .instr_addr(instr_addr),
    .instr_in(instr_in), .alu_flag_z(alu_flag_z), .alu_flag_n(alu_flag_n),
    .alu_op(alu_op), .operand(operand), .reg_we(reg_we), .mem_re(mem_re),
    .mem_we(mem_we), .mem_ack(mem_ack), .done(done), .err(err)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // Synchronous ROM: data for an address appears one cycle later.
  logic [8:0] rom [256];
  always @(posedge Clk) instr_in <= rom[instr_addr];

  // Memory responder: ack on the (ack_at+1)-th consecutive strobe cycle; -1 = never.
  int mem_run = 0;
  int ack_at  = -1;
  always @(posedge Clk) mem_run <= (mem_re || mem_we) ? mem_run + 1 : 0;
  assign mem_ack = (mem_re || mem_we) && (mem_run == ack_at);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    bit         alu_v;
    logic [3:0] op;
    logic [4:0] opnd;
    bit         rw, mr, mw, dn, er;
  } exp_t;

  exp_t exp_q[$];
  int   entry = 0;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("addr#%0d", entry), 32'(instr_addr), 32'(e.addr));
      if (e.alu_v) begin
        check($sformatf("alu_op#%0d", entry), 32'(alu_op), 32'(e.op));
        check($sformatf("operand#%0d", entry), 32'(operand), 32'(e.opnd));
      end
      check($sformatf("reg_we#%0d", entry), 32'(reg_we), 32'(e.rw));
      check($sformatf("mem_re#%0d", entry), 32'(mem_re), 32'(e.mr));
      check($sformatf("mem_we#%0d", entry), 32'(mem_we), 32'(e.mw));
      check($sformatf("done#%0d", entry), 32'(done), 32'(e.dn));
      check($sformatf("err#%0d", entry), 32'(err), 32'(e.er));
      entry++;
    end
  end

  logic [7:0] pc_m;

  task automatic push(input logic [7:0] a, input bit av, input logic [3:0] op,
                      input logic [4:0] od, input bit rw, input bit mr,
                      input bit mw, input bit dn, input bit er);
    exp_t e;
    e.addr = a; e.alu_v = av; e.op = op; e.opnd = od;
    e.rw = rw; e.mr = mr; e.mw = mw; e.dn = dn; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic fd();
    repeat (2) push(pc_m, 0, 4'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_alu(input logic [3:0] op, input logic [4:0] od);
    fd();
    push(pc_m, 1, op, od, 1, 0, 0, 0, 0);
    pc_m = pc_m + 8'd1;
  endtask

  task automatic do_br(input logic [3:0] op, input logic [4:0] od, input bit taken);
    logic [7:0] off;
    fd();
    push(pc_m, 1, op, od, 0, 0, 0, 0, 0);
    off  = {{3{od[4]}}, od};
    pc_m = taken ? pc_m + off : pc_m + 8'd1;
  endtask

  // k = MEM cycle carrying the ack; k = 0 means no ack (timeout path, pc unchanged).
  task automatic do_mem(input bit is_lw, input logic [4:0] od, input int k);
    fd();
    push(pc_m, 1, is_lw ? OP_LW : OP_SW, od, 0, 0, 0, 0, 0);
    if (k == 0) begin
      repeat (MEM_TO) push(pc_m, 0, 4'd0, 5'd0, 0, is_lw, !is_lw, 0, 0);
    end else begin
      repeat (k) push(pc_m, 0, 4'd0, 5'd0, 0, is_lw, !is_lw, 0, 0);
      if (is_lw) push(pc_m, 0, 4'd0, 5'd0, 1, 0, 0, 0, 0);
      pc_m = pc_m + 8'd1;
    end
  endtask

  task automatic do_halt(input int n);
    fd();
    repeat (n) push(pc_m, 0, 4'd0, 5'd0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_err(input int n);
    repeat (n) push(pc_m, 0, 4'd0, 5'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic push_idle();
    push(8'd0, 1, 4'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic rom_fill();
    for (int i = 0; i < 256; i++) rom[i] = W_HALT;
  endtask

  // Returns one time unit after a rising edge once the scoreboard is empty.
  task automatic drain();
    int n = 0;
    do begin
      @(posedge Clk);
      n++;
    end while (exp_q.size() != 0 && n < 400);
    if (exp_q.size() != 0) begin
      check("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    pc_m = 8'd0;
  endtask

  task automatic end_start();
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  logic [3:0] alu_ops [6];
  logic [4:0] alu_ods [6];
  logic [3:0] br_op [5];
  bit         br_z [5], br_n [5], br_t [5];

  initial begin
    #200000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; start = 1'b0; alu_flag_z = 1'b0; alu_flag_n = 1'b0;
    rom_fill();

    // Reset: everything quiet before start.
    do_reset();
    repeat (3) push_idle();
    drain();

    // ADD then HALT, then restart from HALT.
    rom[0] = {OP_ADD, 5'd3}; rom[1] = W_HALT;
    start = 1'b1;
    push_idle();
    do_alu(OP_ADD, 5'd3);
    do_halt(3);
    end_start();
    drain();
    start = 1'b1;
    push(pc_m, 0, 4'd0, 5'd0, 0, 0, 0, 1, 0);
    pc_m = 8'd0;
    do_alu(OP_ADD, 5'd3);
    do_halt(2);
    end_start();
    drain();

    // ALU variety; start held for several cycles must not restart the program.
    alu_ops = '{OP_SUB, OP_SL, OP_SR, OP_INV, OP_MOV, OP_ASG};
    alu_ods = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd31};
    do_reset();
    rom_fill();
    for (int i = 0; i < 6; i++) rom[i] = {alu_ops[i], alu_ods[i]};
    start = 1'b1;
    push_idle();
    for (int i = 0; i < 6; i++) do_alu(alu_ops[i], alu_ods[i]);
    do_halt(2);
    repeat (5) @(posedge Clk);
    #1 start = 1'b0;
    drain();

    // Conditional branches at pc=10 with offset -4.
    br_op = '{OP_BEQ, OP_BEQ, OP_BGE, OP_BNE, OP_BGE};
    br_z  = '{1, 0, 0, 0, 1};
    br_n  = '{0, 0, 1, 0, 0};
    br_t  = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      rom_fill();
      rom[0]  = {OP_JMP, 5'd10};
      rom[10] = {br_op[i], 5'b11100};
      alu_flag_z = br_z[i];
      alu_flag_n = br_n[i];
      start = 1'b1;
      push_idle();
      do_br(OP_JMP, 5'd10, 1);
      do_br(br_op[i], 5'b11100, br_t[i]);
      do_halt(2);
      end_start();
      drain();
    end

    // Jumps with wrap in both directions: 0 -> 240 -> 250 -> 9.
    do_reset();
    rom_fill();
    rom[0] = {OP_JMP, 5'b10000}; rom[240] = {OP_JMP, 5'd10}; rom[250] = {OP_JMP, 5'd15};
    start = 1'b1;
    push_idle();
    do_br(OP_JMP, 5'b10000, 1);
    do_br(OP_JMP, 5'd10, 1);
    do_br(OP_JMP, 5'd15, 1);
    do_halt(2);
    end_start();
    drain();
    check("wrap_pc", 32'(pc_m), 32'd9);

    // LW with ack on the third MEM cycle.
    do_reset();
    rom_fill();
    rom[0] = {OP_LW, 5'd7};
    ack_at = 2;
    start = 1'b1;
    push_idle();
    do_mem(1, 5'd7, 3);
    do_halt(2);
    end_start();
    drain();

    // ADD, SW with immediate ack, HALT.
    do_reset();
    rom_fill();
    rom[0] = {OP_ADD, 5'd1}; rom[1] = {OP_SW, 5'd4};
    ack_at = 0;
    start = 1'b1;
    push_idle();
    do_alu(OP_ADD, 5'd1);
    do_mem(0, 5'd4, 1);
    do_halt(2);
    end_start();
    drain();
`ifdef CTRL_PERF_CNT_EN
    check("cycle_cnt", 32'(cycle_cnt), 32'd9);
    check("instr_cnt", 32'(instr_cnt), 32'd2);
`endif

    // SW timeout into sticky ERR; start ignored; reset clears.
    do_reset();
    rom_fill();
    rom[0] = {OP_SW, 5'd2};
    ack_at = -1;
    start = 1'b1;
    push_idle();
    do_mem(0, 5'd2, 0);
    do_err(3);
    end_start();
    drain();
    start = 1'b1;
    do_err(3);
    end_start();
    drain();
    do_reset();
    push_idle();
    drain();

    // Illegal word goes straight to ERR.
    rom_fill();
    rom[0] = 9'h1A0;
    start = 1'b1;
    push_idle();
    fd();
    do_err(3);
    end_start();
    drain();

    // Reset in the middle of a MEM wait.
    do_reset();
    rom_fill();
    rom[0] = {OP_LW, 5'd1};
    start = 1'b1;
    push_idle();
    fd();
    push(pc_m, 1, OP_LW, 5'd1, 0, 0, 0, 0, 0);
    repeat (2) push(pc_m, 0, 4'd0, 5'd0, 0, 1, 0, 0, 0);
    end_start();
    drain();
    push(pc_m, 0, 4'd0, 5'd0, 0, 1, 0, 0, 0);
    push_idle();
    push_idle();
    Reset_n = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
